discharge_pulse_sequencer: RTL and testbench
============================================

# discharge_pulse_sequencer

Sequences the EDM discharge pulse train from the parameters decoded by the SPI command slave. It consumes the `machine_start`/`machine_stop` strobes and the 16-bit Ton/Toff/Ip/waveform words, then produces the gate-on window, current setpoint and waveform selection for the power stage. Parameter changes take effect only at pulse-period boundaries, so a Ton/Toff/Ip update never truncates or tears a discharge. A 32-bit status word is returned to the SPI slave as `feedback_data`.

## Interface
- No parameters; all widths fixed.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `machine_start` in 1: one-cycle start strobe.
- `machine_stop` in 1: one-cycle stop strobe.
- `Ton_data` in 16: on-time in clk cycles.
- `Toff_data` in 16: off-time in clk cycles.
- `Ip_data` in 16: peak-current setpoint, passed through.
- `waveform_data` in 16: waveform selector, passed through.
- `pulse_on` out 1: discharge gate, high during the ON phase.
- `ip_setpoint` out 16: active Ip.
- `waveform_sel` out 16: active waveform.
- `running` out 1: state is not IDLE.
- `period_done` out 1: one-cycle pulse in the last OFF cycle.
- `param_applied` out 1: one-cycle pulse when a newly loaded active set differs from the previous one.
- `feedback_data` out 32: status word, laid out as follows.
  - [31:16] pulse_count.
  - [15:4] zero.
  - [3] param_error.
  - [2] running.
  - [1:0] state.

## Operation
- **Input stability filter**
  - All four input words are sampled into a 64-bit register `samp` every cycle.
  - `stable` is true when the live inputs equal `samp`.
  - This guards against byte-wise SPI updates, where the low byte and high byte arrive on different cycles.
- **Load event**
  - A load event happens at every IDLE→ON attempt and at every OFF→ON boundary.
  - At a load event, the active set (Ton, Toff, Ip, waveform) is copied from `samp` only if `stable` is true. Otherwise the active set is unchanged.
  - The load is never delayed.
- **States** (2-bit encoding): IDLE=0, ON=1, OFF=2. Encoding 3 is illegal and recovers to IDLE.
- **IDLE**
  - On `machine_start` && !`machine_stop`, perform the load event.
  - If the resulting active Ton ≠ 0: go to ON and clear param_error.
  - Else: stay in IDLE and set param_error.
- **ON**
  - A down-counter is loaded with Ton; ON lasts exactly Ton cycles.
  - At the end of ON, go to OFF with counter = max(Toff, 1).
  - On `machine_stop` in ON: go to OFF next cycle (ON is truncated) and set stop_pending.
- **OFF**
  - OFF lasts max(Toff, 1) cycles. `machine_stop` in OFF sets stop_pending; the current OFF completes.
  - At the end of OFF:
    - If stop_pending: go to IDLE and clear stop_pending.
    - Else: perform the load event. If the new Ton = 0, go to IDLE and set param_error. Otherwise go to ON.
- **Ignored inputs**
  - `machine_start` while running has no effect.
  - `machine_stop` while in IDLE has no effect.
- **Simultaneous start and stop in IDLE**: stop wins; the block stays in IDLE and no load occurs.
- **pulse_count**
  - 16 bits, incremented on every entry into ON.
  - Wraps from 0xFFFF to 0x0000.
  - Cleared only by reset.
- **Passthrough outputs**: `ip_setpoint` and `waveform_sel` always show the active set and hold after stop.

## Timing
- All outputs are registered.
- Reset values:
  - Every output is 0.
  - Active set is 0, `samp` is 0.
  - pulse_count, param_error and stop_pending are 0.
  - State is IDLE.
- A start sampled at clock edge n gives state=ON and `pulse_on`=1 from cycle n+1 through n+Ton. OFF then covers cycles n+Ton+1 through n+Ton+max(Toff,1), followed immediately by ON again, with no gap cycle.
- `period_done` is high in the final OFF cycle, for every period including the one that ends in IDLE.
- `param_applied` is high in the first ON cycle that follows a load which changed any active word.
- A stop sampled at edge m during ON gives `pulse_on`=0 from cycle m+1 and `running`=0 after the full OFF that follows.
- Reset mid-operation: the next cycle shows reset values, `pulse_on` drops immediately, and no drain OFF phase is run.
- The 16-bit counters never underflow, because a length of 0 is either rejected (Ton) or clamped to 1 (Toff).

## Test plan
- Ton=5, Toff=3, stable inputs, start at edge n:
  - `pulse_on` is high for cycles n+1 to n+5 and low for cycles n+6 to n+8, then high again from n+9.
  - `period_done` is high at n+8.
  - pulse_count reaches 2 at n+9.
- Change Ton from 5 to 2 while in ON: the current ON still lasts 5 cycles, the next ON lasts 2, and `param_applied` pulses in the first cycle of the new ON.
- Change only Ton[7:0] on the cycle before an OFF→ON boundary (so `stable` is false there): the old Ton is kept for that period and the new Ton is applied at the following boundary.
- Stop in the 2nd ON cycle with Toff=4: `pulse_on` falls on the next cycle, 4 OFF cycles follow, then IDLE; a start during that OFF is ignored.
- Ton=0 at start: the block stays in IDLE and `feedback_data`[3]=1. Then set Ton=3 and start again: the block runs and bit 3 clears. Toff=0 yields a 1-cycle OFF.
- Simultaneous start+stop in IDLE: the block stays in IDLE. Force pulse_count to 0xFFFF, then enter ON once: the count wraps to 0x0000. Assert `rst` mid-ON: all outputs read 0 on the next cycle.

Source files
------------

// File: rtl/discharge_pulse_sequencer_if.sv
// ============================================================================
// Module      : discharge_pulse_sequencer_if
// Description : Parameter/strobe inputs and power-stage outputs of the EDM
//               discharge pulse sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface discharge_pulse_sequencer_if;
  logic        machine_start;
  logic        machine_stop;
  logic [15:0] Ton_data;
  logic [15:0] Toff_data;
  logic [15:0] Ip_data;
  logic [15:0] waveform_data;
  logic        pulse_on;
  logic [15:0] ip_setpoint;
  logic [15:0] waveform_sel;
  logic        running;
  logic        period_done;
  logic        param_applied;
  logic [31:0] feedback_data;

  modport master (
    output machine_start, machine_stop, Ton_data, Toff_data, Ip_data, waveform_data,
    input  pulse_on, ip_setpoint, waveform_sel, running, period_done, param_applied,
           feedback_data
  );

  modport slave (
    input  machine_start, machine_stop, Ton_data, Toff_data, Ip_data, waveform_data,
    output pulse_on, ip_setpoint, waveform_sel, running, period_done, param_applied,
           feedback_data
  );
endinterface

`default_nettype wire

// File: rtl/discharge_pulse_sequencer.sv
// ============================================================================
// Module      : discharge_pulse_sequencer
// Description : EDM discharge pulse train sequencer; parameters are latched
//               only at pulse-period boundaries and only when stable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module discharge_pulse_sequencer (
  input  wire logic                    clk,
  input  wire logic                    rst,
  discharge_pulse_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t      r_state;
  logic [63:0] r_samp;
  logic [63:0] r_active;
  logic [15:0] r_cnt;
  logic [15:0] r_pulse_count;
  logic        r_param_error;
  logic        r_stop_pending;
  logic        r_pulse_on;
  logic        r_running;
  logic        r_period_done;
  logic        r_param_applied;

  logic [63:0] w_live;
  logic        w_stable;
  logic [63:0] w_load_set;
  logic [15:0] w_load_ton;
  logic        w_changed;
  logic [15:0] w_act_offlen;

  assign w_live       = {bus.Ton_data, bus.Toff_data, bus.Ip_data, bus.waveform_data};
  assign w_stable     = (w_live == r_samp);
  // A half-written word (inputs moved since last cycle) keeps the old active set.
  assign w_load_set   = w_stable ? r_samp : r_active;
  assign w_load_ton   = w_load_set[63:48];
  assign w_changed    = (w_load_set != r_active);
  assign w_act_offlen = (r_active[47:32] == 16'd0) ? 16'd1 : r_active[47:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_samp          <= 64'd0;
      r_active        <= 64'd0;
      r_cnt           <= 16'd0;
      r_pulse_count   <= 16'd0;
      r_param_error   <= 1'b0;
      r_stop_pending  <= 1'b0;
      r_pulse_on      <= 1'b0;
      r_running       <= 1'b0;
      r_period_done   <= 1'b0;
      r_param_applied <= 1'b0;
    end else begin
      r_samp          <= w_live;
      r_period_done   <= 1'b0;
      r_param_applied <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.machine_start && !bus.machine_stop) begin
            r_active <= w_load_set;
            if (w_load_ton != 16'd0) begin
              r_state         <= S_ON;
              r_cnt           <= w_load_ton;
              r_pulse_on      <= 1'b1;
              r_running       <= 1'b1;
              r_pulse_count   <= r_pulse_count + 16'd1;
              r_param_error   <= 1'b0;
              r_param_applied <= w_changed;
            end else begin
              r_param_error <= 1'b1;
            end
          end
        end
        S_ON: begin
          if (bus.machine_stop || (r_cnt == 16'd1)) begin
            r_state       <= S_OFF;
            r_cnt         <= w_act_offlen;
            r_pulse_on    <= 1'b0;
            r_period_done <= (w_act_offlen == 16'd1);
            if (bus.machine_stop) r_stop_pending <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_OFF: begin
          if (r_cnt == 16'd1) begin
            if (r_stop_pending || bus.machine_stop) begin
              r_state        <= S_IDLE;
              r_running      <= 1'b0;
              r_stop_pending <= 1'b0;
            end else begin
              r_active <= w_load_set;
              if (w_load_ton != 16'd0) begin
                r_state         <= S_ON;
                r_cnt           <= w_load_ton;
                r_pulse_on      <= 1'b1;
                r_pulse_count   <= r_pulse_count + 16'd1;
                r_param_applied <= w_changed;
              end else begin
                r_state       <= S_IDLE;
                r_running     <= 1'b0;
                r_param_error <= 1'b1;
              end
            end
          end else begin
            r_cnt         <= r_cnt - 16'd1;
            r_period_done <= (r_cnt == 16'd2);
            if (bus.machine_stop) r_stop_pending <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_pulse_on <= 1'b0;
          r_running  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_on      = r_pulse_on;
  assign bus.ip_setpoint   = r_active[31:16];
  assign bus.waveform_sel  = r_active[15:0];
  assign bus.running       = r_running;
  assign bus.period_done   = r_period_done;
  assign bus.param_applied = r_param_applied;
  assign bus.feedback_data = {r_pulse_count, 12'd0, r_param_error, r_running, r_state};

endmodule

`default_nettype wire

// File: tb/tb_discharge_pulse_sequencer.sv
// ============================================================================
// Module      : tb_discharge_pulse_sequencer
// Description : Randomized self-checking bench against a period-offset model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_discharge_pulse_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  discharge_pulse_sequencer_if bus();

  discharge_pulse_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a running period is described by the current cycle index m_t
  // (1-based), the last ON index and the total period length.
  bit          m_run, m_stop, m_err, m_applied, m_chg;
  logic [15:0] m_ton, m_toff, m_ip, m_wave, m_count;
  logic [63:0] m_samp;
  int          m_t, m_on_end, m_len;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int offlen(input logic [15:0] toff);
    return (toff == 16'd0) ? 1 : int'(toff);
  endfunction

  task automatic m_load(input bit stable, input logic [63:0] live);
    logic [63:0] old;
    old = {m_ton, m_toff, m_ip, m_wave};
    if (stable) {m_ton, m_toff, m_ip, m_wave} = live;
    m_chg = ({m_ton, m_toff, m_ip, m_wave} != old);
  endtask

  task automatic m_begin_period();
    m_run     = 1'b1;
    m_t       = 1;
    m_on_end  = int'(m_ton);
    m_len     = int'(m_ton) + offlen(m_toff);
    m_count   = m_count + 16'd1;
    m_applied = m_chg;
  endtask

  task automatic model_step();
    logic [63:0] live;
    bit          stable;
    live      = {bus.Ton_data, bus.Toff_data, bus.Ip_data, bus.waveform_data};
    stable    = (live == m_samp);
    m_applied = 1'b0;
    if (rst) begin
      m_run = 0; m_stop = 0; m_err = 0;
      {m_ton, m_toff, m_ip, m_wave} = 64'd0;
      m_count = 16'd0; m_samp = 64'd0;
      m_t = 0; m_on_end = 0; m_len = 0;
    end else begin
      if (!m_run) begin
        if (bus.machine_start && !bus.machine_stop) begin
          m_load(stable, live);
          if (m_ton != 16'd0) begin
            m_begin_period();
            m_err = 1'b0;
          end else begin
            m_err = 1'b1;
          end
        end
      end else begin
        if (m_t <= m_on_end) begin
          if (bus.machine_stop) begin
            m_on_end = m_t;
            m_len    = m_t + offlen(m_toff);
            m_stop   = 1'b1;
          end
        end else if (bus.machine_stop) begin
          m_stop = 1'b1;
        end
        if (m_t == m_len) begin
          if (m_stop) begin
            m_run  = 1'b0;
            m_stop = 1'b0;
          end else begin
            m_load(stable, live);
            if (m_ton != 16'd0) m_begin_period();
            else begin
              m_run = 1'b0;
              m_err = 1'b1;
            end
          end
        end else begin
          m_t++;
        end
      end
      m_samp = live;
    end
  endtask

  task automatic compare_all();
    bit         exp_on;
    logic [1:0] exp_state;
    exp_on    = m_run && (m_t <= m_on_end);
    exp_state = !m_run ? 2'd0 : (exp_on ? 2'd1 : 2'd2);
    check_val("pulse_on",      64'(bus.pulse_on),      64'(exp_on));
    check_val("running",       64'(bus.running),       64'(m_run));
    check_val("period_done",   64'(bus.period_done),   64'(m_run && (m_t == m_len)));
    check_val("param_applied", 64'(bus.param_applied), 64'(m_applied));
    check_val("ip_setpoint",   64'(bus.ip_setpoint),   64'(m_ip));
    check_val("waveform_sel",  64'(bus.waveform_sel),  64'(m_wave));
    check_val("feedback_data", 64'(bus.feedback_data),
              64'({m_count, 12'd0, m_err, m_run, exp_state}));
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
    end
  endtask

  task automatic set_params(input logic [15:0] ton, toff, ip, wave);
    bus.Ton_data = ton; bus.Toff_data = toff; bus.Ip_data = ip; bus.waveform_data = wave;
  endtask

  task automatic pulse_start();
    bus.machine_start = 1'b1; tick(); bus.machine_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.machine_stop = 1'b1; tick(); bus.machine_stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_run && k < budget) begin tick(); k++; end
    if (m_run) check_val("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_last_off(input int budget);
    int k = 0;
    while (!(m_run && m_t == m_len && m_t > m_on_end) && k < budget) begin tick(); k++; end
    if (k >= budget) check_val("boundary_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    bus.machine_start = 1'b0;
    bus.machine_stop  = 1'b0;
    set_params(16'd0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    tick(2);
    check_val("reset_feedback", 64'(bus.feedback_data), 64'd0);
    check_val("reset_pulse_on", 64'(bus.pulse_on), 64'd0);
    rst = 1'b0;

    // Basic train Ton=5, Toff=3
    set_params(16'd5, 16'd3, 16'h1234, 16'd2);
    tick(2);
    pulse_start();
    check_val("first_on", 64'(bus.pulse_on), 64'd1);
    tick(7);
    check_val("done_n8", 64'(bus.period_done), 64'd1);
    tick();
    check_val("count_n9", 64'(bus.feedback_data[31:16]), 64'd2);

    // Ton 5 -> 2 during ON
    bus.Ton_data = 16'd2;
    tick(20);

    // Byte-wise update right before an OFF->ON boundary
    wait_last_off(40);
    bus.Ton_data[7:0] = 8'd4;
    tick(25);
    pulse_stop();
    wait_idle(40);

    // Stop in 2nd ON cycle, Toff=4, start ignored during OFF
    set_params(16'd3, 16'd4, 16'h0055, 16'd1);
    tick();
    pulse_start();
    tick();
    pulse_stop();
    check_val("stop_gate_off", 64'(bus.pulse_on), 64'd0);
    pulse_start();
    wait_idle(20);
    check_val("stopped_idle", 64'(bus.running), 64'd0);

    // Ton=0 rejected, then accepted; Toff=0 clamps to one cycle
    set_params(16'd0, 16'd0, 16'h0777, 16'd3);
    tick();
    pulse_start();
    check_val("ton0_err", 64'(bus.feedback_data[3]), 64'd1);
    bus.Ton_data = 16'd3;
    tick();
    pulse_start();
    check_val("ton3_err_clr", 64'(bus.feedback_data[3]), 64'd0);
    tick(12);
    pulse_stop();
    wait_idle(20);

    // Start+stop together in IDLE
    bus.machine_start = 1'b1; bus.machine_stop = 1'b1;
    tick();
    bus.machine_start = 1'b0; bus.machine_stop = 1'b0;
    check_val("start_stop_idle", 64'(bus.running), 64'd0);

    // pulse_count wrap
    force dut.r_pulse_count = 16'hFFFF;
    m_count = 16'hFFFF;
    tick();
    release dut.r_pulse_count;
    pulse_start();
    check_val("count_wrap", 64'(bus.feedback_data[31:16]), 64'd0);
    tick();

    // Reset mid-ON
    rst = 1'b1;
    tick();
    check_val("rst_mid_on", 64'({bus.pulse_on, bus.running, bus.feedback_data,
                                bus.ip_setpoint, bus.waveform_sel}), 64'd0);
    rst = 1'b0;

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      bus.machine_start = ($urandom_range(0, 9) == 0);
      bus.machine_stop  = ($urandom_range(0, 39) == 0);
      rst               = ($urandom_range(0, 599) == 0);
      case ($urandom_range(0, 19))
        0: set_params(($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6)),
                      16'($urandom_range(0, 4)), 16'($urandom), 16'($urandom));
        1: bus.Ton_data[7:0] = 8'($urandom_range(0, 5));
        2: bus.Ip_data[15:8] = 8'($urandom);
        default: ;
      endcase
      tick();
    end
    bus.machine_start = 1'b0; bus.machine_stop = 1'b0; rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
